// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: sequencer state encoding and default sizing.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH_PEND,
        DRAIN,
        HALTED
    } pipe_seq_state_t;

    localparam int unsigned PIPE_DRAIN_CYCLES_DEF = 4;
    localparam int unsigned PIPE_CNT_W_DEF        = 16;

endpackage

// File: rtl/pipeline_ctrl_sequencer_if.sv
// Signal bundle for pipeline_ctrl_sequencer; seq faces the sequencer, tb faces its driver.
interface pipeline_ctrl_sequencer_if #(
    parameter int unsigned CNT_W = 16
) (
    input logic CLK
);
    logic             nRST;
    logic             freeze;
    logic             threeInstrFlush;
    logic             ihit;
    logic             dmem_req;
    logic             dhit;
    logic             halt_in;
    logic             pc_en;
    logic             fd_en;
    logic             dx_en;
    logic             xm_en;
    logic             mw_en;
    logic             fd_flush;
    logic             dx_flush;
    logic             xm_flush;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport seq (
        input  CLK, nRST, freeze, threeInstrFlush, ihit, dmem_req, dhit, halt_in,
        output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
               halt_out, stall_cnt, flush_cnt
    );

    modport tb (
        input  CLK, pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
               halt_out, stall_cnt, flush_cnt,
        output nRST, freeze, threeInstrFlush, ihit, dmem_req, dhit, halt_in
    );

endinterface

// File: rtl/pipeline_ctrl_sequencer.sv
// Per-core pipeline latch-enable/flush sequencer with redirect discard and halt drain.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = PIPE_DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = PIPE_CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             freeze,
    input  logic             threeInstrFlush,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             halt_in,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_seq_state_t  state, nextState;
    logic [CNT_W-1:0] drainCnt, nextDrain;

    always_comb begin
        nextState = state;
        nextDrain = drainCnt;
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_en     = 1'b0;
        mw_en     = 1'b0;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_flush  = 1'b0;
        case (state)
            RUN, FLUSH_PEND: begin
                if (halt_in) begin
                    mw_en     = 1'b1;
                    nextState = DRAIN;
                    nextDrain = CNT_W'(DRAIN_CYCLES - 1);
                end else if (dmem_req && !dhit) begin
                    // full freeze; upstream holds redirect/freeze so nothing is latched here
                end else if (threeInstrFlush) begin
                    {pc_en, fd_en, dx_en, xm_en, mw_en} = '1;
                    {fd_flush, dx_flush, xm_flush}      = '1;
                    if (state == FLUSH_PEND || !ihit) nextState = FLUSH_PEND;
                end else if (freeze || !ihit) begin
                    dx_en    = 1'b1;
                    dx_flush = 1'b1;
                    xm_en    = 1'b1;
                    mw_en    = 1'b1;
                end else if (state == FLUSH_PEND) begin
                    // stale fetch arrives: bubble it and keep PC on the redirect target
                    {fd_en, dx_en, xm_en, mw_en} = '1;
                    fd_flush  = 1'b1;
                    nextState = RUN;
                end else begin
                    {pc_en, fd_en, dx_en, xm_en, mw_en} = '1;
                end
            end
            DRAIN: begin
                {fd_en, dx_en, xm_en, mw_en}   = '1;
                {fd_flush, dx_flush, xm_flush} = '1;
                if (drainCnt == '0) nextState = HALTED;
                else                nextDrain = drainCnt - CNT_W'(1);
            end
            default: ;
        endcase
        if (!nRST) begin
            {pc_en, fd_en, dx_en, xm_en, mw_en} = '0;
            {fd_flush, dx_flush, xm_flush}      = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= RUN;
            drainCnt <= '0;
            halt_out <= 1'b0;
        end else begin
            state    <= nextState;
            drainCnt <= nextDrain;
            halt_out <= (nextState == HALTED);
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic             runLike;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    // in RUN/FLUSH_PEND only an accepted redirect drives xm_flush
    assign runLike = (state == RUN) || (state == FLUSH_PEND);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (runLike && !pc_en && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
            if (runLike && xm_flush && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCnt;
    assign flush_cnt = flushCnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Directed self-checking bench for pipeline_ctrl_sequencer (honours PIPE_PERF_CNT_EN).
module tb_pipeline_ctrl_sequencer;

    // control vector order: pc fd dx xm mw | fdF dxF xmF
    localparam logic [7:0] ADV     = 8'b11111_000;
    localparam logic [7:0] BUBBLE  = 8'b00111_010;
    localparam logic [7:0] STALL   = 8'b00000_000;
    localparam logic [7:0] FLUSH3  = 8'b11111_111;
    localparam logic [7:0] DISCARD = 8'b01111_100;
    localparam logic [7:0] HALTV   = 8'b00001_000;
    localparam logic [7:0] DRAINV  = 8'b01111_111;
    localparam logic [7:0] IDLE    = 8'b00000_000;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd3;
    localparam logic [15:0] EXP_FLUSH = 16'd2;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
    localparam logic [15:0] EXP_FLUSH = 16'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_sequencer_if #(.CNT_W(16)) bus (.CLK(clk));

    pipeline_ctrl_sequencer #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .CLK            (bus.CLK),
        .nRST           (bus.nRST),
        .freeze         (bus.freeze),
        .threeInstrFlush(bus.threeInstrFlush),
        .ihit           (bus.ihit),
        .dmem_req       (bus.dmem_req),
        .dhit           (bus.dhit),
        .halt_in        (bus.halt_in),
        .pc_en          (bus.pc_en),
        .fd_en          (bus.fd_en),
        .dx_en          (bus.dx_en),
        .xm_en          (bus.xm_en),
        .mw_en          (bus.mw_en),
        .fd_flush       (bus.fd_flush),
        .dx_flush       (bus.dx_flush),
        .xm_flush       (bus.xm_flush),
        .halt_out       (bus.halt_out),
        .stall_cnt      (bus.stall_cnt),
        .flush_cnt      (bus.flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctrlVec();
        return {bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
                bus.fd_flush, bus.dx_flush, bus.xm_flush};
    endfunction

    // drive one cycle of inputs, check outputs mid-cycle, then advance past the edge
    task automatic cycle(input string tag, input logic frz, input logic tif, input logic ih,
                         input logic dreq, input logic dh, input logic hlt,
                         input logic [7:0] expCtrl, input logic expHalt);
        bus.freeze          = frz;
        bus.threeInstrFlush = tif;
        bus.ihit            = ih;
        bus.dmem_req        = dreq;
        bus.dhit            = dh;
        bus.halt_in         = hlt;
        @(negedge clk);
        checkVal({tag, "_ctrl"}, 32'(ctrlVec()), 32'(expCtrl));
        checkVal({tag, "_halt"}, 32'(bus.halt_out), 32'(expHalt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.nRST = 1'b0;
        bus.freeze = 1'b0; bus.threeInstrFlush = 1'b0; bus.ihit = 1'b0;
        bus.dmem_req = 1'b0; bus.dhit = 1'b0; bus.halt_in = 1'b0;
        @(posedge clk);
        #1;

        // reset: outputs gated off even with active inputs
        cycle("rst0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b0);
        cycle("rst1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, IDLE, 1'b0);
        checkVal("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        checkVal("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        bus.nRST = 1'b1;

        for (int i = 0; i < 10; i++)
            cycle("adv", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV, 1'b0);

        cycle("freeze",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BUBBLE, 1'b0);
        cycle("freeze_after",1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV,    1'b0);

        for (int i = 0; i < 3; i++)
            cycle("memstall", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, STALL, 1'b0);
        cycle("memstall_done", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, FLUSH3, 1'b0);
        cycle("post_redirect", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV,    1'b0);

        cycle("redir_miss",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FLUSH3,  1'b0);
        cycle("pend_wait",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BUBBLE,  1'b0);
        cycle("pend_discard",1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DISCARD, 1'b0);
        cycle("pend_run",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV,     1'b0);

        cycle("redir_a",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FLUSH3,  1'b0);
        cycle("redir_in_pend",1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FLUSH3,  1'b0);
        cycle("repend_discard",1'b0,1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DISCARD, 1'b0);
        cycle("repend_run",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV,     1'b0);

        // halt outranks mem stall and redirect; DRAIN ignores freeze/ihit/redirect
        cycle("halt",   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, HALTV,  1'b0);
        cycle("drain0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DRAINV, 1'b0);
        cycle("drain1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DRAINV, 1'b0);
        cycle("drain2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DRAINV, 1'b0);
        cycle("drain3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DRAINV, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle("halted", i[0], ~i[0], i[1], 1'b0, 1'b0, 1'b0, IDLE, 1'b1);

        bus.nRST = 1'b0;
        cycle("rst_halted", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b1);
        bus.nRST = 1'b1;
        cycle("after_rst",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV,  1'b0);

        cycle("halt2",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, HALTV,  1'b0);
        cycle("drain2a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DRAINV, 1'b0);
        bus.nRST = 1'b0;
        cycle("rst_drain", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b0);
        bus.nRST = 1'b1;
        cycle("drain_rst_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV, 1'b0);

        for (int i = 0; i < 3; i++)
            cycle("cnt_freeze", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BUBBLE, 1'b0);
        for (int i = 0; i < 2; i++)
            cycle("cnt_redir",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FLUSH3, 1'b0);
        cycle("cnt_adv", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADV, 1'b0);
        checkVal("stall_cnt", 32'(bus.stall_cnt), 32'(EXP_STALL));
        checkVal("flush_cnt", 32'(bus.flush_cnt), 32'(EXP_FLUSH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
